// File: rtl/rv32i_pkg.sv
// Shared RV32I memory-access types: funct3 load/store formats, store-buffer entry, output-stage state.
package rv32i_pkg;

  localparam logic [2:0] FMT_B  = 3'b000;
  localparam logic [2:0] FMT_H  = 3'b001;
  localparam logic [2:0] FMT_W  = 3'b010;
  localparam logic [2:0] FMT_BU = 3'b100;
  localparam logic [2:0] FMT_HU = 3'b101;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } st_entry_t;

  typedef enum logic {
    OS_IDLE,
    OS_SEND
  } out_state_t;

endpackage

// File: rtl/st_align.sv
// Store lane steering: replicates store data across byte lanes and builds write strobes.
// Inverse of the load converter's extraction; purely combinational.
module st_align
  import rv32i_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic [2:0]  format,
  output st_entry_t   entry,
  output logic        fmt_ok,
  output logic        misaligned
);

  always_comb begin
    entry.addr  = addr[31:2];
    entry.wdata = '0;
    entry.wstrb = '0;
    fmt_ok      = 1'b1;
    misaligned  = 1'b0;
    case (format)
      FMT_B: begin
        entry.wdata = {4{data[7:0]}};
        entry.wstrb = 4'b0001 << addr[1:0];
      end
      FMT_H: begin
        // Misaligned halfwords are force-aligned by using only addr[1].
        entry.wdata = {2{data[15:0]}};
        entry.wstrb = addr[1] ? 4'b1100 : 4'b0011;
        misaligned  = addr[0];
      end
      FMT_W: begin
        entry.wdata = data;
        entry.wstrb = 4'b1111;
        misaligned  = |addr[1:0];
      end
      default: fmt_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/st_buffer.sv
// Store buffer: aligns SB/SH/SW, queues DEPTH entries plus one output stage, drains via req/ack.
// ST_MISALIGN_TRAP_EN: when defined, misaligned SH/SW are rejected with st_fault instead of force-aligned.
module st_buffer
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_format,
  output logic        st_fault,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  st_entry_t        fifo_mem [DEPTH];
  st_entry_t        al_entry;
  st_entry_t        head;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  out_state_t       state;
  logic             fmt_ok;
  logic             misaligned;
  logic             reject;
  logic             accept;
  logic             enq;
  logic             pop;
  logic             fifo_full;
  logic             fifo_nonempty;

  st_align u_align (
    .addr       (st_addr),
    .data       (st_data),
    .format     (st_format),
    .entry      (al_entry),
    .fmt_ok     (fmt_ok),
    .misaligned (misaligned)
  );

`ifdef ST_MISALIGN_TRAP_EN
  assign reject = !fmt_ok || misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign reject = !fmt_ok;
`endif

  assign fifo_full     = (count == CW'(DEPTH));
  assign fifo_nonempty = (count != '0);
  assign st_ready      = !fifo_full;
  assign accept        = st_valid && st_ready;
  assign enq           = accept && !reject;
  // The output stage pulls the head when idle, or when the current write is acked.
  assign pop           = fifo_nonempty && ((state == OS_IDLE) || mem_ack);
  assign head          = fifo_mem[rd_ptr];
  assign empty         = !fifo_nonempty && (state == OS_IDLE);

  always_ff @(posedge clk) begin
    if (enq) fifo_mem[wr_ptr] <= al_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      st_fault <= 1'b0;
    end else begin
      st_fault <= accept && reject;
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= OS_IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      case (state)
        OS_IDLE: begin
          if (fifo_nonempty) begin
            mem_addr  <= {head.addr, 2'b00};
            mem_wdata <= head.wdata;
            mem_wstrb <= head.wstrb;
            mem_req   <= 1'b1;
            state     <= OS_SEND;
          end
        end
        OS_SEND: begin
          if (mem_ack) begin
            if (fifo_nonempty) begin
              mem_addr  <= {head.addr, 2'b00};
              mem_wdata <= head.wdata;
              mem_wstrb <= head.wstrb;
            end else begin
              mem_req <= 1'b0;
              state   <= OS_IDLE;
            end
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= OS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_st_buffer.sv
// Scoreboard bench for st_buffer: directed stores queue expected writes, a monitor checks each mem write.
module tb_st_buffer;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_format;
  logic        st_fault;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic        empty;

  st_buffer #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_format (st_format),
    .st_fault  (st_fault),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ack   (mem_ack),
    .empty     (empty)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [67:0] sb[$];
  logic        tb_bad;
  logic        pend_fault;
  int          cyc      = 0;
  int          last_cyc = 0;
  int          gap      = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drives one store starting at a negedge; returns at the negedge after the accepting edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       input logic bad, input logic push,
                       input logic [31:0] ea, input logic [31:0] ew, input logic [3:0] es);
    int n;
    st_valid  = 1'b1;
    st_addr   = a;
    st_data   = d;
    st_format = f;
    tb_bad    = bad;
    if (push) sb.push_back({ea, ew, es});
    n = 0;
    while (!st_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n == 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL store_timeout: st_ready stuck at %b, required 1", st_ready);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    st_valid = 1'b0;
    tb_bad   = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (!(sb.size() == 0 && empty) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, (sb.size() == 0 && empty)}, 32'd1);
  endtask

  // Monitor: samples just after the falling edge; a write completes on the next rising edge.
  always begin
    logic [67:0] e;
    @(negedge clk);
    #1;
    cyc++;
    if (rst) begin
      pend_fault = 1'b0;
    end else begin
      chk("st_fault", {31'd0, st_fault}, {31'd0, pend_fault});
      pend_fault = st_valid && st_ready && tb_bad;
      if (mem_req && mem_ack) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %h wdata %h wstrb %b, required none", mem_addr, mem_wdata, mem_wstrb);
        end else begin
          e = sb.pop_front();
          chk("mem_addr", mem_addr, e[67:36]);
          chk("mem_wdata", mem_wdata, e[35:4]);
          chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e[3:0]});
          gap      = cyc - last_cyc;
          last_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    st_valid  = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    st_format = '0;
    mem_ack   = 1'b0;
    tb_bad    = 1'b0;
    pend_fault = 1'b0;
    #1 rst = 1'b1;
    #3;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_st_fault", {31'd0, st_fault}, 32'd0);
    chk("rst_st_ready", {31'd0, st_ready}, 32'd1);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Lane steering, SB to byte 3, plus first-write latency.
    mem_ack = 1'b1;
    store(32'h103, 32'h0000_00A5, 3'b000, 1'b0, 1'b1, 32'h100, 32'hA5A5_A5A5, 4'b1000);
    chk("sb_req_n1", {31'd0, mem_req}, 32'd0);
    chk("sb_empty_n1", {31'd0, empty}, 32'd0);
    idle();
    @(negedge clk);
    chk("sb_req_n2", {31'd0, mem_req}, 32'd1);
    chk("sb_addr_n2", mem_addr, 32'h100);
    wait_drain("sb_drain");

    // Back-to-back drain with ack held high.
    store(32'h202, 32'h0000_BEEF, 3'b001, 1'b0, 1'b1, 32'h200, 32'hBEEF_BEEF, 4'b1100);
    store(32'h300, 32'h1234_5678, 3'b010, 1'b0, 1'b1, 32'h300, 32'h1234_5678, 4'b1111);
    idle();
    wait_drain("b2b_drain");
    chk("b2b_gap", gap, 32'd1);

    // Full / backpressure: DEPTH+1 stores with ack low.
    mem_ack = 1'b0;
    store(32'h400, 32'h1111_1111, 3'b010, 1'b0, 1'b1, 32'h400, 32'h1111_1111, 4'b1111);
    store(32'h404, 32'h2222_2222, 3'b010, 1'b0, 1'b1, 32'h404, 32'h2222_2222, 4'b1111);
    store(32'h408, 32'h3333_3333, 3'b010, 1'b0, 1'b1, 32'h408, 32'h3333_3333, 4'b1111);
    chk("full_ready", {31'd0, st_ready}, 32'd0);
    st_addr = 32'h40C;
    st_data = 32'h4444_4444;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_hold_ready", {31'd0, st_ready}, 32'd0);
      chk("full_hold_addr", mem_addr, 32'h400);
      chk("full_hold_wdata", mem_wdata, 32'h1111_1111);
      chk("full_hold_req", {31'd0, mem_req}, 32'd1);
    end
    idle();
    @(negedge clk);
    mem_ack = 1'b1;
    wait_drain("full_drain");

    // Invalid funct3: consumed, not queued, one-cycle fault.
    store(32'h500, 32'hDEAD_BEEF, 3'b011, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0000);
    idle();
    chk("fault_empty_n1", {31'd0, empty}, 32'd1);
    @(negedge clk);
    chk("fault_empty_n2", {31'd0, empty}, 32'd1);
    @(negedge clk);

    // Misaligned SW.
`ifdef ST_MISALIGN_TRAP_EN
    store(32'h101, 32'hCAFE_F00D, 3'b010, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0000);
    idle();
    chk("mis_empty", {31'd0, empty}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("mis_no_req", {31'd0, mem_req}, 32'd0);
`else
    store(32'h101, 32'hCAFE_F00D, 3'b010, 1'b0, 1'b1, 32'h100, 32'hCAFE_F00D, 4'b1111);
    idle();
    chk("mis_empty", {31'd0, empty}, 32'd0);
`endif
    wait_drain("mis_drain");

    // Async reset while in SEND with two entries queued.
    mem_ack = 1'b0;
    store(32'h600, 32'hAAAA_0000, 3'b010, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
    store(32'h604, 32'hAAAA_0001, 3'b010, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
    store(32'h608, 32'hAAAA_0002, 3'b010, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
    idle();
    chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
    chk("pre_rst_ready", {31'd0, st_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, mem_req}, 32'd0);
    chk("arst_empty", {31'd0, empty}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_empty", {31'd0, empty}, 32'd1);
    chk("post_rst_ready", {31'd0, st_ready}, 32'd1);
    @(negedge clk);
    chk("post_rst_req", {31'd0, mem_req}, 32'd0);

    // Buffer works again after reset; SB to byte 1.
    mem_ack = 1'b1;
    store(32'h001, 32'h0000_005A, 3'b000, 1'b0, 1'b1, 32'h000, 32'h5A5A_5A5A, 4'b0010);
    idle();
    wait_drain("final_drain");
    repeat (3) @(negedge clk);
    chk("sb_leftover", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
